nested_loop_counter: RTL and testbench

- Parametrised multi-level loop counter generating tile/loop indices and per-level wrap events for the VEGETA TPU controllers.
- Level 0 is the innermost loop. Each level counts 0..end_i inclusive, and a carry ripples outward when a level wraps.
- A start/done FSM wraps the counter, so a controller can launch one full nest traversal and wait for completion.
- Event outputs go through a fixed-depth pipeline, so they align with downstream pipelined datapaths.

---
 rtl/nested_loop_counter.sv | 196 +++++++++++++++++++
 tb/tb_nested_loop_counter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// nested_loop_counter
//
// Multi-level loop counter that generates tile/loop indices and per-level
// wrap events for the VEGETA TPU controllers. Level 0 is the innermost loop.
// Each level counts 0..end_i inclusive, and a carry ripples outward whenever
// a level wraps. A small IDLE/RUN/DONE FSM lets a controller launch one full
// nest traversal and then wait for completion. Event outputs pass through a
// fixed-depth shift pipeline so they line up with pipelined datapaths.
//
// Optional feature (compile-time macro NESTED_LOOP_COUNTER_AUTO_RESTART_EN):
//   when defined, the final count leaves the FSM in RUN with all counters
//   wrapped to 0, so the nest repeats until load or reset. DONE is then
//   unreachable and done stays 0. When undefined, the FSM stops in DONE
//   after one traversal.
//
// Parameters:
//   NUM_LEVELS    number of nested loop levels (>= 1)
//   COUNTER_WIDTH width of each level's counter and end value
//   EVENT_LATENCY cycles from the counting cycle to wrap_event/last_event (>= 1)
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   enable      advance the count this cycle (only acts in RUN)
//   load        capture end_vals, clear counters, flush events, go to IDLE
//   end_vals    terminal value per level, level i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   start       begin a traversal (acts in IDLE or DONE)
//   count_vals  current index per level, same packing as end_vals
//   wrap_event  per-level wrap pulse, delayed EVENT_LATENCY cycles
//   last_event  pulse for the final count of the whole nest, delayed EVENT_LATENCY cycles
//   busy        high while in RUN
//   done        high while in DONE
//
// Control handshake: start is a single-cycle request sampled on the clock
// edge; it is honoured only in IDLE or DONE and ignored in RUN. busy rises
// the cycle after an accepted start and falls the cycle after the final
// count, when done rises. done stays high until the next start or load.
// Priority on any edge is reset > load > start > enable.

module nested_loop_counter #(
    parameter int NUM_LEVELS    = 3,
    parameter int COUNTER_WIDTH = 16,
    parameter int EVENT_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                load,
    input  logic [NUM_LEVELS*COUNTER_WIDTH-1:0] end_vals,
    input  logic                                start,
    output logic [NUM_LEVELS*COUNTER_WIDTH-1:0] count_vals,
    output logic [NUM_LEVELS-1:0]               wrap_event,
    output logic                                last_event,
    output logic                                busy,
    output logic                                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // FSM state register; kept as a named enum so checkers can bind to it.
    state_t state_q;

    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_LEVELS];
    logic [COUNTER_WIDTH-1:0] end_q [NUM_LEVELS];

    // carry[i] is term_(i-1): every level below i sits at its end value.
    // carry[0] is tied high so level 0 always advances on an enabled cycle.
    logic [NUM_LEVELS:0]   carry;
    logic                  advance;
    logic                  final_count;
    logic [NUM_LEVELS-1:0] raw_wrap;
    logic [NUM_LEVELS:0]   raw_ev;

    // Event pipeline: bit NUM_LEVELS carries last, the low bits carry wraps.
    logic [NUM_LEVELS:0]   ev_pipe [EVENT_LATENCY];

    always_comb begin
        carry[0] = 1'b1;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            carry[i+1] = carry[i] & (cnt_q[i] == end_q[i]);
        end
    end

    assign advance     = (state_q == S_RUN) & enable;
    assign final_count = advance & carry[NUM_LEVELS];
    assign raw_wrap    = advance ? carry[NUM_LEVELS:1] : '0;
    assign raw_ev      = {raw_wrap[NUM_LEVELS-1], raw_wrap};

    // Counters and end registers. A level advances only when all inner
    // levels are at their end value; at its own end it wraps to 0, so on
    // the final count every level returns to 0 together.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                cnt_q[i] <= '0;
                end_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                end_q[i] <= end_vals[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                cnt_q[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                if (carry[i]) begin
                    if (cnt_q[i] == end_q[i]) begin
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + COUNTER_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Control FSM with registered busy/done, updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (final_count) begin
`ifdef NESTED_LOOP_COUNTER_AUTO_RESTART_EN
                        // Counters have wrapped to 0; simply keep running.
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
`else
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    // Counters are already 0 here, so a restart needs no clear.
                    if (start) begin
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Event delay line. It shifts every cycle regardless of enable, so an
    // event raised in cycle t is visible for exactly cycle t+EVENT_LATENCY.
    // load discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            for (int k = 0; k < EVENT_LATENCY; k++) begin
                ev_pipe[k] <= '0;
            end
        end else begin
            ev_pipe[0] <= raw_ev;
            for (int k = 1; k < EVENT_LATENCY; k++) begin
                ev_pipe[k] <= ev_pipe[k-1];
            end
        end
    end

    assign wrap_event = ev_pipe[EVENT_LATENCY-1][NUM_LEVELS-1:0];
    assign last_event = ev_pipe[EVENT_LATENCY-1][NUM_LEVELS];

    genvar g;
    generate
        for (g = 0; g < NUM_LEVELS; g++) begin : g_pack
            assign count_vals[g*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_nested_loop_counter.sv
// Testbench for nested_loop_counter (NUM_LEVELS=3, COUNTER_WIDTH=16,
// EVENT_LATENCY=2). The reference model tracks the nest as one linear index
// and derives per-level counts and wrap events arithmetically. Expected
// event words go into exp_q after each clock edge and are popped and
// compared on the following falling edges.

module tb_nested_loop_counter;

    localparam int NL  = 3;
    localparam int CW  = 16;
    localparam int LAT = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             enable;
    logic             load;
    logic             start;
    logic [NL*CW-1:0] end_vals;
    logic [NL*CW-1:0] count_vals;
    logic [NL-1:0]    wrap_event;
    logic             last_event;
    logic             busy;
    logic             done;

    nested_loop_counter #(
        .NUM_LEVELS   (NL),
        .COUNTER_WIDTH(CW),
        .EVENT_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .end_vals  (end_vals),
        .start     (start),
        .count_vals(count_vals),
        .wrap_event(wrap_event),
        .last_event(last_event),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_on    = 1'b0;

    logic [NL:0] exp_q[$];

    // reference model state
    int m_end [NL];
    int m_idx;
    int m_state;

    function automatic logic [NL*CW-1:0] pack3(input int l2, input int l1, input int l0);
        return {CW'(l2), CW'(l1), CW'(l0)};
    endfunction

    function automatic int m_total();
        int p = 1;
        for (int i = 0; i < NL; i++) p = p * (m_end[i] + 1);
        return p;
    endfunction

    function automatic logic [NL*CW-1:0] exp_counts();
        int div = 1;
        logic [NL*CW-1:0] r = '0;
        for (int i = 0; i < NL; i++) begin
            r[i*CW +: CW] = CW'((m_idx / div) % (m_end[i] + 1));
            div = div * (m_end[i] + 1);
        end
        return r;
    endfunction

    // driver: apply one cycle of inputs, advance the model, queue the
    // expected event word for this cycle
    task automatic drive_cycle(input logic rst, input logic ld, input logic st,
                               input logic en, input logic [NL*CW-1:0] ev);
        logic [NL:0] raw;
        int p;
        int total;
        reset    = rst;
        load     = ld;
        start    = st;
        enable   = en;
        end_vals = ev;
        raw   = '0;
        total = m_total();
        if (!rst && !ld && m_state == M_RUN && en) begin
            p = 1;
            for (int i = 0; i < NL; i++) begin
                p = p * (m_end[i] + 1);
                raw[i] = (((m_idx + 1) % p) == 0);
            end
            raw[NL] = raw[NL-1];
        end
        if (rst) begin
            for (int i = 0; i < NL; i++) m_end[i] = 0;
            m_idx   = 0;
            m_state = M_IDLE;
        end else if (ld) begin
            for (int i = 0; i < NL; i++) m_end[i] = int'(ev[i*CW +: CW]);
            m_idx   = 0;
            m_state = M_IDLE;
        end else if (st && m_state != M_RUN) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN && en) begin
            if (m_idx + 1 == total) begin
                m_idx = 0;
`ifdef NESTED_LOOP_COUNTER_AUTO_RESTART_EN
                m_state = M_RUN;
`else
                m_state = M_DONE;
`endif
            end else begin
                m_idx = m_idx + 1;
            end
        end
        @(posedge clk);
        if (rst || ld) begin
            foreach (exp_q[k]) exp_q[k] = '0;
        end
        exp_q.push_back(raw);
        #1;
    endtask

    // scoreboard: event outputs against the expected queue
    always @(negedge clk) begin
        logic [NL:0] e;
        if (sb_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({last_event, wrap_event} !== e)
                $display("FAIL events @%0t: got %b expected %b", $time, {last_event, wrap_event}, e);
            else
                n_pass++;
        end
    end

    task automatic test_reset();
        drive_cycle(0, 1, 0, 0, pack3(2, 1, 3));
        drive_cycle(0, 0, 1, 0, '0);
        repeat (5) drive_cycle(0, 0, 0, 1, '0);
        drive_cycle(1, 0, 0, 1, '0);
        n_checks++;
        if (count_vals !== '0) $display("FAIL reset_count: got %h expected 0", count_vals);
        else n_pass++;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if ({last_event, wrap_event} !== 4'b0000)
            $display("FAIL reset_events: got %b expected 0000", {last_event, wrap_event});
        else n_pass++;
    endtask

    task automatic test_traversal();
        int w0 = 0, w1 = 0, w2 = 0, lc = 0;
        drive_cycle(0, 1, 0, 0, pack3(2, 1, 3));
        drive_cycle(0, 0, 1, 0, '0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL trav_busy_start: got %b expected 1", busy);
        else n_pass++;
        for (int k = 0; k < 24 + 3; k++) begin
            drive_cycle(0, 0, 0, (k < 24) ? 1'b1 : 1'b0, '0);
            if (wrap_event[0]) w0++;
            if (wrap_event[1]) w1++;
            if (wrap_event[2]) w2++;
            if (last_event) lc++;
            n_checks++;
            if (count_vals !== exp_counts())
                $display("FAIL trav_count k=%0d: got %h expected %h", k, count_vals, exp_counts());
            else n_pass++;
            if (k == 23) begin
                n_checks++;
                if ({busy, done} !== {1'(m_state == M_RUN), 1'(m_state == M_DONE)})
                    $display("FAIL trav_done: got busy/done %b%b expected %b%b", busy, done,
                             m_state == M_RUN, m_state == M_DONE);
                else n_pass++;
            end
        end
        n_checks++;
        if ({w2, w1, w0, lc} !== {32'd1, 32'd3, 32'd6, 32'd1})
            $display("FAIL trav_event_counts: got w2=%0d w1=%0d w0=%0d last=%0d expected 1 3 6 1",
                     w2, w1, w0, lc);
        else n_pass++;
    endtask

    task automatic test_enable_toggle();
        drive_cycle(0, 1, 0, 0, pack3(2, 1, 3));
        drive_cycle(0, 0, 1, 0, '0);
        for (int k = 0; k < 60; k++) begin
            logic en;
            en = (k < 40) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            // start while running must be ignored
            drive_cycle(0, 0, (k == 5), en, '0);
            n_checks++;
            if (count_vals !== exp_counts() || busy !== 1'(m_state == M_RUN))
                $display("FAIL toggle k=%0d: got %h busy %b expected %h busy %b", k, count_vals, busy,
                         exp_counts(), m_state == M_RUN);
            else n_pass++;
        end
    endtask

    task automatic test_mid_run_load();
        int targets [2] = '{10, 8};
        for (int t = 0; t < 2; t++) begin
            drive_cycle(0, 1, 0, 0, pack3(2, 1, 3));
            drive_cycle(0, 0, 1, 0, '0);
            repeat (targets[t]) drive_cycle(0, 0, 0, 1, '0);
            n_checks++;
            if (count_vals !== pack3(1, 0, (targets[t] == 10) ? 2 : 0))
                $display("FAIL midload_pre t=%0d: got %h expected %h", t, count_vals, exp_counts());
            else n_pass++;
            drive_cycle(0, 1, 0, 1, pack3(0, 0, 1));
            n_checks++;
            if (count_vals !== '0 || {busy, done} !== 2'b00 || {last_event, wrap_event} !== 4'b0000)
                $display("FAIL midload_post t=%0d: got cnt %h bd %b%b ev %b expected all 0", t,
                         count_vals, busy, done, {last_event, wrap_event});
            else n_pass++;
            drive_cycle(0, 0, 1, 0, '0);
            drive_cycle(0, 0, 0, 1, '0);
            drive_cycle(0, 0, 0, 1, '0);
            n_checks++;
            if (done !== 1'(m_state == M_DONE) || count_vals !== '0)
                $display("FAIL midload_done t=%0d: got done %b cnt %h expected %b 0", t, done,
                         count_vals, m_state == M_DONE);
            else n_pass++;
            drive_cycle(0, 0, 0, 0, '0);
            n_checks++;
            if ({last_event, wrap_event} !== 4'b1111)
                $display("FAIL midload_final_events t=%0d: got %b expected 1111", t, {last_event, wrap_event});
            else n_pass++;
        end
    endtask

    task automatic test_load_start_same();
        drive_cycle(0, 1, 1, 0, pack3(0, 0, 1));
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL ldst_same: got busy/done %b%b expected 00", busy, done);
        else n_pass++;
        drive_cycle(0, 0, 1, 0, '0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL ldst_next_start: got busy %b expected 1", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, 1, 0, 0, pack3(1, 0, 1));
        for (int k = 0; k < 40; k++) begin
            drive_cycle(0, 0, (m_state != M_RUN), 1'($urandom_range(0, 1)), '0);
            n_checks++;
            if (count_vals !== exp_counts() || busy !== 1'(m_state == M_RUN) || done !== 1'(m_state == M_DONE))
                $display("FAIL b2b k=%0d: got %h bd %b%b expected %h bd %b%b", k, count_vals, busy, done,
                         exp_counts(), m_state == M_RUN, m_state == M_DONE);
            else n_pass++;
        end
    endtask

`ifdef NESTED_LOOP_COUNTER_AUTO_RESTART_EN
    task automatic test_auto_restart();
        int lc = 0;
        drive_cycle(0, 1, 0, 0, pack3(0, 0, 1));
        drive_cycle(0, 0, 1, 0, '0);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(0, 0, 0, (k < 6), '0);
            if (last_event) lc++;
            n_checks++;
            if ({busy, done} !== 2'b10) $display("FAIL auto_busy k=%0d: got %b%b expected 10", k, busy, done);
            else n_pass++;
        end
        n_checks++;
        if (lc !== 3) $display("FAIL auto_last_count: got %0d expected 3", lc);
        else n_pass++;
    endtask
`else
    task automatic test_done_restart();
        drive_cycle(0, 1, 0, 0, pack3(0, 0, 1));
        drive_cycle(0, 0, 1, 0, '0);
        repeat (2) drive_cycle(0, 0, 0, 1, '0);
        repeat (3) begin
            drive_cycle(0, 0, 0, 1, '0);
            n_checks++;
            if (done !== 1'b1 || count_vals !== '0)
                $display("FAIL done_hold: got done %b cnt %h expected 1 0", done, count_vals);
            else n_pass++;
        end
        drive_cycle(0, 0, 1, 1, '0);
        n_checks++;
        if ({busy, done} !== 2'b10 || count_vals !== '0)
            $display("FAIL done_restart: got bd %b%b cnt %h expected 10 0", busy, done, count_vals);
        else n_pass++;
        drive_cycle(0, 0, 0, 1, '0);
        n_checks++;
        if (count_vals !== pack3(0, 0, 1))
            $display("FAIL done_restart_count: got %h expected %h", count_vals, pack3(0, 0, 1));
        else n_pass++;
    endtask
`endif

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        end_vals = '0;
        m_idx    = 0;
        m_state  = M_IDLE;
        for (int i = 0; i < NL; i++) m_end[i] = 0;
        for (int k = 0; k < LAT - 1; k++) exp_q.push_back('0);
        drive_cycle(1, 0, 0, 0, '0);
        sb_on = 1'b1;

        test_reset();
        test_traversal();
        test_enable_toggle();
        test_mid_run_load();
        test_load_start_same();
        test_back_to_back();
`ifdef NESTED_LOOP_COUNTER_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_done_restart();
`endif
        repeat (LAT + 1) drive_cycle(0, 0, 0, 0, '0);
        sb_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
